// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store memory controller.
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        RD_LO,
        RD_HI,
        WRITE,
        RESP
    } lsu_state_e;

    localparam int MEM_BYTES_DEF = 10;

    // {MemSize, MemD}: equal bits let the memory capture addresses, unequal bits make it hold them
    localparam logic [1:0] MODE_BYTE = 2'b00;
    localparam logic [1:0] MODE_HOLD = 2'b10;

endpackage

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller sequencing a byte-addressed data memory (byte/word loads, merge-on-byte-store).
// Optional macro LSU_ALIGN_CHECK_EN rejects word accesses at odd addresses.
//
// state | meaning
// IDLE  | accepting a request; memory holds its captured addresses
// SETUP | present first read/write address to the memory
// RD_LO | read byte at addr (word load also presents addr+1)
// RD_HI | read byte at addr+1
// WRITE | one-cycle two-byte write at addr
// RESP  | one-cycle response pulse
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int MEM_BYTES = MEM_BYTES_DEF,
    parameter int ADDR_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_word,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [15:0]       req_wdata,
    output logic              resp_valid,
    output logic [15:0]       resp_rdata,
    output logic              resp_err,
    output logic              MemRead,
    output logic              MemWrite,
    output logic              MemSize,
    output logic              MemD,
    output logic [ADDR_W-1:0] ReadAddr,
    output logic [ADDR_W-1:0] WriteAddr,
    output logic [15:0]       writeData,
    input  logic [15:0]       readData
);

    localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(MEM_BYTES);
    localparam logic [ADDR_W:0] ONE   = (ADDR_W+1)'(1);

    lsu_state_e  state_q, state_d;
    logic [7:0]  addr_q;
    logic [15:0] wdata_q;
    logic        word_q, write_q, signed_q, err_q;
    logic [7:0]  lo_q, lo_d, hi_q, hi_d;

    logic [ADDR_W:0] addr_ext, addr_nxt;
    logic            range_err, align_err, req_bad;
    logic [7:0]      addr_inc, rd_addr8, wr_addr8;
    logic [1:0]      mode_sel;
    logic [15:0]     rdata;
    logic            unused_rdata_hi;

    assign unused_rdata_hi = ^readData[15:8];

    // Byte stores count as two-byte accesses because the memory always writes addr and addr+1
    assign addr_ext  = {1'b0, req_addr};
    assign addr_nxt  = addr_ext + ONE;
    assign range_err = (addr_ext >= LIMIT) || ((req_word || req_write) && (addr_nxt >= LIMIT));
`ifdef LSU_ALIGN_CHECK_EN
    assign align_err = req_word & req_addr[0];
`else
    assign align_err = 1'b0;
`endif
    assign req_bad   = range_err | align_err;
    assign addr_inc  = addr_q + 8'd1;

    always_comb begin
        if (err_q || write_q)  rdata = 16'h0000;
        else if (word_q)       rdata = {hi_q, lo_q};
        else if (signed_q)     rdata = {{8{lo_q[7]}}, lo_q};
        else                   rdata = {8'h00, lo_q};
    end

    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = 16'h0000;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        mode_sel   = MODE_BYTE;
        rd_addr8   = 8'h00;
        wr_addr8   = 8'h00;
        writeData  = 16'h0000;
        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                mode_sel  = MODE_HOLD;
                if (req_valid) state_d = req_bad ? RESP : SETUP;
            end
            SETUP: begin
                rd_addr8 = write_q ? addr_inc : addr_q;
                wr_addr8 = write_q ? addr_q : 8'h00;
                if (!write_q)    state_d = RD_LO;
                else if (word_q) state_d = WRITE;
                else             state_d = RD_HI;
            end
            RD_LO: begin
                MemRead  = 1'b1;
                rd_addr8 = addr_inc;
                state_d  = word_q ? RD_HI : RESP;
            end
            RD_HI: begin
                MemRead  = 1'b1;
                rd_addr8 = addr_inc;
                wr_addr8 = write_q ? addr_q : 8'h00;
                state_d  = write_q ? WRITE : RESP;
            end
            WRITE: begin
                MemWrite  = 1'b1;
                wr_addr8  = addr_q;
                writeData = word_q ? wdata_q : {hi_q, wdata_q[7:0]};
                state_d   = RESP;
            end
            RESP: begin
                mode_sel   = MODE_HOLD;
                resp_valid = 1'b1;
                resp_err   = err_q;
                resp_rdata = rdata;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign {MemSize, MemD} = mode_sel;
    assign ReadAddr        = {{(ADDR_W-8){1'b0}}, rd_addr8};
    assign WriteAddr       = {{(ADDR_W-8){1'b0}}, wr_addr8};

    always_comb begin
        lo_d = lo_q;
        hi_d = hi_q;
        if (state_q == RD_LO) lo_d = readData[7:0];
        if (state_q == RD_HI) hi_d = readData[7:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            addr_q   <= 8'h00;
            wdata_q  <= 16'h0000;
            word_q   <= 1'b0;
            write_q  <= 1'b0;
            signed_q <= 1'b0;
            err_q    <= 1'b0;
            lo_q     <= 8'h00;
            hi_q     <= 8'h00;
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            if (state_q == IDLE && req_valid) begin
                addr_q   <= req_addr[7:0];
                wdata_q  <= req_wdata;
                word_q   <= req_word;
                write_q  <= req_write;
                signed_q <= req_signed;
                err_q    <= req_bad;
            end
        end
    end

endmodule
